multicycle_core: RTL and testbench

//  Parametrised multi-cycle successor to the single-cycle 8-bit mainboard datapath.
//  - Fetches 16-bit instructions [op|rd|ra|rb] over a ready/ack instruction port.
//  - Executes ALU/MUL/LDI/LD/ST/branch/HALT through an explicit FSM.
//  - Accesses a separate data-memory port with a req/ack handshake, so slow memories stall cleanly.

---
 rtl/core_pkg.sv | 51 +++++
 rtl/core_alu.sv | 38 +++
 rtl/multicycle_core.sv | 158 +++++++++++++++
 tb/tb_multicycle_core.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and instruction-field positions for the multi-cycle core.
// Latency: n/a (types only).
// Backpressure: n/a.
package core_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_MUL  = 4'h5,
        OP_MULH = 4'h6,
        OP_LDI  = 4'h7,
        OP_LD   = 4'h8,
        OP_ST   = 4'h9,
        OP_BR   = 4'hA,
        OP_HALT = 4'hB
    } opcode_e;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;

    typedef enum logic [3:0] {
        C_ALWAYS = 4'h0,
        C_Z      = 4'h1,
        C_NZ     = 4'h2,
        C_N      = 4'h3,
        C_NN     = 4'h4
    } cond_e;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RA_MSB  = 7;
    localparam int RA_LSB  = 4;
    localparam int RB_MSB  = 3;
    localparam int RB_LSB  = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Opcodes 0..8 produce a register result; only the ALU group 0..6 touches flags.
    function automatic logic op_writes(input logic [3:0] op);
        return op <= 4'h8;
    endfunction

    function automatic logic op_sets_flags(input logic [3:0] op);
        return op <= 4'h6;
    endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational ALU: add/sub/logic plus low and high halves of the unsigned product.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result is valid whenever inputs are.
module core_alu
    import core_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  opcode_e           op,
    output logic [DATA_W-1:0] res,
    output logic              zero,
    output logic              neg
);

    logic [2*DATA_W-1:0] prod;

    assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    always_comb begin
        res = '0;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_MUL:  res = prod[DATA_W-1:0];
            OP_MULH: res = prod[2*DATA_W-1:DATA_W];
            default: res = '0;
        endcase
    end

    assign zero = (res == '0);
    assign neg  = res[DATA_W-1];

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle FETCH/DECODE/EXEC/[MEM]/WB core with a register file and req/ack memory ports.
// Latency: 4 cycles per ALU/LDI/BR instruction, 5 for LD/ST, plus one per memory wait cycle.
// Backpressure: holds req and address/data stable until ack; requests drop the cycle after ack.
module multicycle_core
    import core_pkg::*;
#(
    parameter int              DATA_W   = 8,
    parameter int              NREGS    = 16,
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [PC_W-1:0]   pc,
    output logic              flag_z,
    output logic              flag_n,
    output logic              halted
);

    localparam int              IDX_W  = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [PC_W-1:0] PC_ONE = 1;

    state_e            state, next_state;
    logic [15:0]       instr;
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] op_a, op_b, res_q, rd_a, rd_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_zero, alu_neg;
    logic [PC_W-1:0]   br_target;
    logic              br_taken, cond_true;
    logic              imem_req_d, dmem_req_d, dmem_we_d;

    opcode_e    op;
    logic [3:0] rd, ra, rb;
    logic [7:0] imm8;

    assign op   = opcode_e'(instr[OP_MSB:OP_LSB]);
    assign rd   = instr[RD_MSB:RD_LSB];
    assign ra   = instr[RA_MSB:RA_LSB];
    assign rb   = instr[RB_MSB:RB_LSB];
    assign imm8 = instr[IMM_MSB:IMM_LSB];

    assign imem_addr  = pc;
    assign dmem_addr  = op_a;
    assign dmem_wdata = op_b;

    // Register indices beyond the file size read as zero.
    always_comb begin
        rd_a = (int'(ra) < NREGS) ? regs[ra[IDX_W-1:0]] : '0;
        rd_b = (int'(rb) < NREGS) ? regs[rb[IDX_W-1:0]] : '0;
    end

    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(rd))
            C_ALWAYS: cond_true = 1'b1;
            C_Z:      cond_true = flag_z;
            C_NZ:     cond_true = !flag_z;
            C_N:      cond_true = flag_n;
            C_NN:     cond_true = !flag_n;
            default:  cond_true = 1'b0;
        endcase
    end

    core_alu #(.DATA_W(DATA_W)) u_alu (
        .a    (op_a),
        .b    (op_b),
        .op   (op),
        .res  (alu_res),
        .zero (alu_zero),
        .neg  (alu_neg)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:  if (imem_req && imem_ack) next_state = DECODE;
            DECODE: next_state = EXEC;
            EXEC: begin
                if (op == OP_LD || op == OP_ST) next_state = MEM;
                else if (op == OP_HALT)         next_state = HALT;
                else                            next_state = WB;
            end
            MEM:    if (dmem_req && dmem_ack) next_state = WB;
            WB:     next_state = FETCH;
            HALT:   next_state = HALT;
            default: next_state = FETCH;
        endcase
    end

    // Request strobes are registered from next_state so they rise on entry and drop right after ack.
    always_comb begin
        imem_req_d = (next_state == FETCH);
        dmem_req_d = (next_state == MEM);
        dmem_we_d  = (next_state == MEM) && (op == OP_ST);
        halted     = (state == HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            imem_req  <= 1'b0;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            instr     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            res_q     <= '0;
            br_taken  <= 1'b0;
            br_target <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            imem_req <= imem_req_d;
            dmem_req <= dmem_req_d;
            dmem_we  <= dmem_we_d;
            case (state)
                FETCH:  if (imem_req && imem_ack) instr <= imem_rdata;
                DECODE: begin
                    op_a <= rd_a;
                    op_b <= rd_b;
                end
                EXEC: begin
                    res_q     <= (op == OP_LDI) ? DATA_W'(imm8) : alu_res;
                    br_taken  <= (op == OP_BR) && cond_true;
                    br_target <= pc + PC_W'($signed(imm8));
                    if (op_sets_flags(op)) begin
                        flag_z <= alu_zero;
                        flag_n <= alu_neg;
                    end
                end
                MEM:    if (dmem_req && dmem_ack && !dmem_we) res_q <= dmem_rdata;
                WB: begin
                    if (op_writes(op) && int'(rd) < NREGS) regs[rd[IDX_W-1:0]] <= res_q;
                    pc <= br_taken ? br_target : pc + PC_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: table of ALU vectors, hand-written timing/branch/halt sequences,
// and random programs checked against an instruction-level interpreter.
module tb_multicycle_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    logic [15:0] imem_addr, imem_rdata, pc;
    logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
    logic        flag_z, flag_n, halted;

    always #5 clk = ~clk;

    multicycle_core dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .pc         (pc),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .halted     (halted)
    );

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } dtxn_t;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b, res;
        logic       z, n;
    } vec_t;

    logic [15:0] imem [65536];
    logic [7:0]  dmem [256];
    logic [15:0] fetch_q[$], exp_f[$];
    int          fetch_cyc[$];
    dtxn_t       d_q[$], exp_d[$];
    logic        exp_z, exp_n;
    int          cyc = 0;
    int          n_vec = 0, n_err = 0;
    bit          i_rand = 0, d_rand = 0, spur = 0, i_hold = 0;
    int          d_wait = 0, d_unstable = 0;
    int          i_cnt, i_tgt, d_cnt, d_tgt;
    bit          i_busy = 0, d_busy = 0;
    dtxn_t       d_first, d_cur;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_req) begin
            if (!i_busy) begin
                i_busy = 1;
                i_cnt  = 0;
                i_tgt  = i_rand ? int'($urandom_range(0, 3)) : 0;
            end
            if (!i_hold && i_cnt >= i_tgt) begin
                imem_ack   = 1'b1;
                imem_rdata = imem[imem_addr];
                i_busy     = 0;
                fetch_q.push_back(imem_addr);
                fetch_cyc.push_back(cyc);
            end else begin
                imem_ack = 1'b0;
                i_cnt++;
            end
        end else begin
            i_busy     = 0;
            imem_ack   = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_rdata = 16'($urandom);
        end
    end

    always @(negedge clk) begin
        if (dmem_req) begin
            d_cur = {dmem_we, dmem_addr, dmem_wdata};
            if (!d_busy) begin
                d_busy  = 1;
                d_cnt   = 0;
                d_tgt   = d_rand ? int'($urandom_range(0, 4)) : d_wait;
                d_first = d_cur;
            end else if (d_cur !== d_first) begin
                d_unstable++;
            end
            if (d_cnt >= d_tgt) begin
                dmem_ack = 1'b1;
                d_busy   = 0;
                d_q.push_back(d_cur);
                if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                else         dmem_rdata = dmem[dmem_addr];
            end else begin
                dmem_ack   = 1'b0;
                dmem_rdata = 8'($urandom);
                d_cnt++;
            end
        end else begin
            d_busy     = 0;
            dmem_ack   = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            dmem_rdata = 8'($urandom);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_halt();
        foreach (imem[k]) imem[k] = 16'hB000;
    endtask

    task automatic reset_core();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fetch_q.delete();
        fetch_cyc.delete();
        d_q.delete();
        d_unstable = 0;
    endtask

    task automatic wait_halt(input int budget, output bit ok);
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (halted) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_fetches(input int n, input int budget, output bit ok);
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (fetch_q.size() >= n) begin
                ok = 1;
                break;
            end
        end
    endtask

    // Instruction-level interpreter: one architectural step per instruction, no notion of cycles.
    task automatic model_run();
        logic [7:0]  r  [16];
        logic [7:0]  dm [256];
        logic [15:0] mpc, ins;
        logic [7:0]  a, b, res, imm;
        logic [3:0]  op, rd, ra, rb;
        logic        mz, mn, tk, done;
        int          prod;
        foreach (r[k]) r[k] = 8'h00;
        foreach (dm[k]) dm[k] = dmem[k];
        exp_f.delete();
        exp_d.delete();
        mpc = 16'h0000; mz = 0; mn = 0; done = 0; exp_z = 0; exp_n = 0;
        for (int s = 0; s < 2000 && !done; s++) begin
            exp_f.push_back(mpc);
            ins = imem[mpc];
            op = ins[15:12]; rd = ins[11:8]; ra = ins[7:4]; rb = ins[3:0]; imm = ins[7:0];
            a = r[ra]; b = r[rb];
            prod = int'(a) * int'(b);
            res = 8'h00;
            case (op)
                4'h0: res = a + b;
                4'h1: res = a - b;
                4'h2: res = a & b;
                4'h3: res = a | b;
                4'h4: res = a ^ b;
                4'h5: res = prod[7:0];
                4'h6: res = prod[15:8];
                default: res = 8'h00;
            endcase
            if (op <= 4'h6) begin
                mz = (res == 8'h00);
                mn = res[7];
                r[rd] = res;
            end else if (op == 4'h7) begin
                r[rd] = imm;
            end else if (op == 4'h8) begin
                exp_d.push_back({1'b0, a, b});
                r[rd] = dm[a];
            end else if (op == 4'h9) begin
                exp_d.push_back({1'b1, a, b});
                dm[a] = b;
            end
            if (op == 4'hB) begin
                exp_z = mz;
                exp_n = mn;
                done  = 1;
            end else if (op == 4'hA) begin
                case (rd)
                    4'h0: tk = 1;
                    4'h1: tk = mz;
                    4'h2: tk = !mz;
                    4'h3: tk = mn;
                    4'h4: tk = !mn;
                    default: tk = 0;
                endcase
                mpc = tk ? mpc + {{8{imm[7]}}, imm} : mpc + 16'd1;
            end else begin
                mpc = mpc + 16'd1;
            end
        end
    endtask

    vec_t tbl [11];

    initial begin
        bit ok;
        int cnt, pc0, nmin;
        logic [15:0] exp_seq [6];

        tbl[0]  = '{4'h0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        tbl[1]  = '{4'h0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        tbl[2]  = '{4'h1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b1};
        tbl[3]  = '{4'h1, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0};
        tbl[4]  = '{4'h2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        tbl[5]  = '{4'h3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b1};
        tbl[6]  = '{4'h4, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0};
        tbl[7]  = '{4'h5, 8'hC8, 8'h03, 8'h58, 1'b0, 1'b0};
        tbl[8]  = '{4'h6, 8'hC8, 8'h03, 8'h02, 1'b0, 1'b0};
        tbl[9]  = '{4'h6, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b1};
        tbl[10] = '{4'h5, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0};

        imem_ack = 0; dmem_ack = 0; imem_rdata = 0; dmem_rdata = 0;
        foreach (dmem[k]) dmem[k] = 8'h00;

        // Reset state, then reset again while a fetch is pending.
        fill_halt();
        for (int i = 1; i < 16; i++) imem[i-1] = {4'h7, 4'(i), 8'(8'h10 + i)};
        reset_core();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_halted", halted, 0);
        chk("rst_flags", {flag_z, flag_n}, 2'b00);
        @(negedge clk);
        chk("rst_imem_req_rise", imem_req, 1);
        wait_fetches(15, 300, ok);
        chk("pre_fetches", ok, 1);
        i_hold = 1;
        repeat (4) @(negedge clk);
        chk("stalled_fetch_req", imem_req, 1);
        chk("stalled_fetch_pc", pc, 16'd15);
        rst = 1'b1;
        for (int k = 0; k < 16; k++) imem[k] = {4'h9, 4'h0, 4'h0, 4'(k)};
        imem[16] = 16'hB000;
        i_hold = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fetch_q.delete(); fetch_cyc.delete(); d_q.delete();
        chk("midrst_pc", pc, 16'h0000);
        chk("midrst_imem_req", imem_req, 0);
        @(negedge clk);
        chk("midrst_imem_req_rise", imem_req, 1);
        wait_halt(400, ok);
        chk("midrst_halt", ok, 1);
        chk("midrst_nstores", d_q.size(), 16);
        cnt = 0;
        foreach (d_q[k]) if (d_q[k].wdata != 8'h00 || d_q[k].addr != 8'h00) cnt++;
        chk("midrst_regs_zero", cnt, 0);

        // Table of single ALU ops, rd == ra to exercise operand capture.
        for (int i = 0; i < 11; i++) begin
            fill_halt();
            imem[0] = {4'h7, 4'h1, tbl[i].a};
            imem[1] = {4'h7, 4'h2, tbl[i].b};
            imem[2] = {tbl[i].op, 4'h1, 4'h1, 4'h2};
            imem[3] = 16'h9001;
            reset_core();
            wait_halt(200, ok);
            chk($sformatf("tbl%0d_halt", i), ok, 1);
            chk($sformatf("tbl%0d_nst", i), d_q.size(), 1);
            if (d_q.size() > 0) chk($sformatf("tbl%0d_res", i), d_q[0].wdata, tbl[i].res);
            chk($sformatf("tbl%0d_z", i), flag_z, tbl[i].z);
            chk($sformatf("tbl%0d_n", i), flag_n, tbl[i].n);
        end

        // Zero-wait latency: LDI/LDI/ADD take 4 cycles each, ST takes 5.
        fill_halt();
        imem[0] = 16'h71FF; imem[1] = 16'h7201; imem[2] = 16'h0312; imem[3] = 16'h9003;
        reset_core();
        wait_halt(200, ok);
        chk("lat_halt", ok, 1);
        chk("lat_nfetch", fetch_cyc.size(), 5);
        if (fetch_cyc.size() >= 5) begin
            chk("lat_ldi1", fetch_cyc[1] - fetch_cyc[0], 4);
            chk("lat_ldi2", fetch_cyc[2] - fetch_cyc[1], 4);
            chk("lat_add", fetch_cyc[3] - fetch_cyc[2], 4);
            chk("lat_st", fetch_cyc[4] - fetch_cyc[3], 5);
        end
        if (d_q.size() > 0) chk("lat_r3", d_q[0].wdata, 8'h00);
        chk("lat_z", flag_z, 1);
        chk("lat_n", flag_n, 0);

        // Stalled data memory: three wait cycles per access.
        fill_halt();
        dmem[8'h10] = 8'h00;
        imem[0] = 16'h7110; imem[1] = 16'h725A; imem[2] = 16'h9012;
        imem[3] = 16'h8610; imem[4] = 16'h9006;
        d_wait = 3;
        reset_core();
        wait_halt(300, ok);
        chk("mem_halt", ok, 1);
        chk("mem_nfetch", fetch_cyc.size(), 6);
        if (fetch_cyc.size() >= 5) begin
            chk("mem_st_cycles", fetch_cyc[3] - fetch_cyc[2], 8);
            chk("mem_ld_cycles", fetch_cyc[4] - fetch_cyc[3], 8);
        end
        chk("mem_stable", d_unstable, 0);
        chk("mem_ntxn", d_q.size(), 3);
        if (d_q.size() >= 3) begin
            chk("mem_st_txn", d_q[0], {1'b1, 8'h10, 8'h5A});
            chk("mem_ld_we", d_q[1].we, 0);
            chk("mem_ld_addr", d_q[1].addr, 8'h10);
            chk("mem_r6", d_q[2].wdata, 8'h5A);
        end
        d_wait = 0;

        // Branches: not-taken !Z, taken Z forward, taken Z backward by 2.
        fill_halt();
        imem[0] = 16'h7133; imem[1] = 16'h1711; imem[2] = 16'hA205;
        imem[3] = 16'hA103; imem[6] = 16'hA1FE;
        exp_seq = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd6, 16'd4};
        reset_core();
        wait_halt(200, ok);
        chk("br_halt", ok, 1);
        chk("br_nfetch", fetch_q.size(), 6);
        for (int k = 0; k < 6 && k < fetch_q.size(); k++)
            chk($sformatf("br_fetch%0d", k), fetch_q[k], exp_seq[k]);
        chk("br_halt_pc", pc, 16'd4);

        // PC wrap at the top of the address space and branch-to-self.
        fill_halt();
        imem[0] = 16'hA0FF; imem[16'hFFFF] = 16'hA001;
        reset_core();
        wait_fetches(3, 100, ok);
        chk("wrap_fetches", ok, 1);
        if (fetch_q.size() >= 3) begin
            chk("wrap_down", fetch_q[1], 16'hFFFF);
            chk("wrap_up", fetch_q[2], 16'h0000);
        end
        imem[0] = 16'hA000;
        reset_core();
        wait_fetches(3, 100, ok);
        chk("self_fetches", ok, 1);
        if (fetch_q.size() >= 3) begin
            chk("self_1", fetch_q[1], 16'h0000);
            chk("self_2", fetch_q[2], 16'h0000);
        end

        // HALT is terminal: no requests, pc frozen; reset restarts at 0.
        fill_halt();
        imem[0] = 16'hC000; imem[1] = 16'hD123; imem[2] = 16'h7155;
        reset_core();
        wait_halt(200, ok);
        chk("halt_reached", ok, 1);
        chk("halt_pc", pc, 16'd3);
        cnt = 0; pc0 = 0;
        repeat (20) begin
            @(negedge clk);
            if (imem_req || dmem_req) cnt++;
            if (pc != 16'd3 || !halted) pc0++;
        end
        chk("halt_no_req", cnt, 0);
        chk("halt_frozen", pc0, 0);
        reset_core();
        chk("halt_rst_halted", halted, 0);
        chk("halt_rst_pc", pc, 16'h0000);
        wait_fetches(1, 50, ok);
        chk("halt_rst_fetch", ok, 1);
        if (fetch_q.size() >= 1) chk("halt_rst_addr", fetch_q[0], 16'h0000);

        // Random programs with random waits and spurious acks.
        i_rand = 1; d_rand = 1; spur = 1;
        for (int p = 0; p < 6; p++) begin
            int L, mx, pick;
            logic [3:0] rop;
            L = 40;
            fill_halt();
            foreach (dmem[k]) dmem[k] = 8'($urandom);
            for (int i = 0; i < L; i++) begin
                pick = $urandom_range(0, 14);
                rop = (pick <= 10) ? 4'(pick) : 4'(pick + 1);
                if (rop == 4'hA) begin
                    mx = (L - i > 4) ? 4 : L - i;
                    imem[i] = {4'hA, 4'($urandom_range(0, 15)), 8'($urandom_range(1, mx))};
                end else begin
                    imem[i] = {rop, 12'($urandom)};
                end
            end
            for (int k = 0; k < 16; k++) imem[L + k] = {4'h9, 4'h0, 4'h0, 4'(k)};
            model_run();
            reset_core();
            wait_halt(5000, ok);
            chk($sformatf("rnd%0d_halt", p), ok, 1);
            chk($sformatf("rnd%0d_nfetch", p), fetch_q.size(), exp_f.size());
            nmin = (fetch_q.size() < exp_f.size()) ? fetch_q.size() : exp_f.size();
            for (int k = 0; k < nmin; k++)
                chk($sformatf("rnd%0d_fetch%0d", p, k), fetch_q[k], exp_f[k]);
            chk($sformatf("rnd%0d_ntxn", p), d_q.size(), exp_d.size());
            nmin = (d_q.size() < exp_d.size()) ? d_q.size() : exp_d.size();
            for (int k = 0; k < nmin; k++)
                chk($sformatf("rnd%0d_txn%0d", p, k), d_q[k], exp_d[k]);
            chk($sformatf("rnd%0d_stable", p), d_unstable, 0);
            chk($sformatf("rnd%0d_z", p), flag_z, exp_z);
            chk($sformatf("rnd%0d_n", p), flag_n, exp_n);
            if (exp_f.size() > 0) chk($sformatf("rnd%0d_pc", p), pc, exp_f[exp_f.size() - 1]);
        end
        spur = 0; i_rand = 0; d_rand = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
